ddr3_app_responder: RTL and testbench

//  Synthesizable responder for the MIG-style DDR3 user (app) interface. Accepts app_en/app_cmd/app_addr and write-data

---
 rtl/ddr3_app_responder_pkg.sv | 19 +
 rtl/ddr3_resp_fifo.sv | 54 +++++
 rtl/ddr3_app_responder.sv | 192 +++++++++++++++++++
 tb/tb_ddr3_app_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_app_responder_pkg.sv
// Shared command codes, engine states and LFSR helpers for the DDR3 app-interface responder.
package ddr3_app_responder_pkg;

   localparam logic [2:0]  CMD_WR    = 3'b000;
   localparam logic [2:0]  CMD_RD    = 3'b001;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC_WR,
      ST_EXEC_RD
   } eng_state_e;

   // Galois-free right-shift LFSR, taps 16/14/13/11
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

endpackage

// File: rtl/ddr3_resp_fifo.sv
// Synchronous FIFO with head and head+1 peek, and a pop of up to two entries per cycle.
module ddr3_resp_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH_BITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic [1:0]            pop_cnt,
   output logic [WIDTH-1:0]      dout,
   output logic [WIDTH-1:0]      dout_next,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_BITS:0]   count
);

   localparam int unsigned DEPTH = 2 ** DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] rd_ptr;
   logic [DEPTH_BITS:0]   cnt;
   logic [DEPTH_BITS:0]   pop_req;
   logic [DEPTH_BITS:0]   pop_amt;
   logic                  wr_en;

   assign full      = (cnt == FULL_CNT);
   assign empty     = (cnt == '0);
   assign count     = cnt;
   assign wr_en     = push && !full;
   assign pop_req   = (DEPTH_BITS + 1)'(pop_cnt);
   assign pop_amt   = (pop_req > cnt) ? cnt : pop_req;
   assign dout      = mem[rd_ptr];
   assign dout_next = mem[rd_ptr + DEPTH_BITS'(1)];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
         rd_ptr <= rd_ptr + DEPTH_BITS'(pop_amt);
         cnt    <= cnt + (DEPTH_BITS + 1)'(wr_en) - pop_amt;
      end
   end

endmodule

// File: rtl/ddr3_app_responder.sv
// MIG-style DDR3 app-interface responder: queues commands and write beats, executes them
// against an on-chip byte-enabled RAM and returns read data as two 32-bit beats.
module ddr3_app_responder
   import ddr3_app_responder_pkg::*;
#(
   parameter int unsigned MEM_ADDR_DEPTH = 28,
   parameter int unsigned RAM_DEPTH_BITS = 10,
   parameter int unsigned CMD_FIFO_BITS  = 2,
   parameter int unsigned WDF_FIFO_BITS  = 3,
   parameter int unsigned RD_LATENCY     = 4,
   parameter int unsigned CALIB_CYCLES   = 64,
   parameter int unsigned STALL_EN       = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   output logic                      o_init_calib_complete,
   output logic                      o_app_rdy,
   input  logic                      i_app_en,
   input  logic [2:0]                i_app_cmd,
   input  logic [MEM_ADDR_DEPTH-1:0] i_app_addr,
   output logic                      o_app_wdf_rdy,
   input  logic                      i_app_wdf_wren,
   input  logic [31:0]               i_app_wdf_data,
   input  logic [3:0]                i_app_wdf_mask,
   input  logic                      i_app_wdf_end,
   output logic                      o_app_rd_data_valid,
   output logic                      o_app_rd_data_end,
   output logic [31:0]               o_app_rd_data,
   output logic                      o_err_stb
);

   localparam int unsigned CMD_W = 3 + MEM_ADDR_DEPTH;
   localparam int unsigned CAL_W = $clog2(CALIB_CYCLES + 1);

   logic [CAL_W-1:0] cal_cnt;
   logic             calib;
   logic [15:0]      lfsr;
   logic             stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cal_cnt <= '0;
         calib   <= 1'b0;
         lfsr    <= LFSR_SEED;
      end else begin
         lfsr <= lfsr_next(lfsr);
         if (!calib) begin
            cal_cnt <= cal_cnt + CAL_W'(1);
            if (cal_cnt == CAL_W'(CALIB_CYCLES - 1)) calib <= 1'b1;
         end
      end
   end

   assign stall                 = (STALL_EN != 0) && lfsr[0];
   assign o_init_calib_complete = calib;

   logic [CMD_W-1:0]       cmd_head, cmd_next;
   logic                   cmd_full, cmd_empty, cmd_pop;
   logic [CMD_FIFO_BITS:0] cmd_count;
   logic [35:0]            wdf_head, wdf_next;
   logic                   wdf_full, wdf_empty;
   logic [1:0]             wdf_pop_cnt;
   logic [WDF_FIFO_BITS:0] wdf_count;

   assign o_app_rdy     = calib && !cmd_full && !stall;
   assign o_app_wdf_rdy = calib && !wdf_full && !stall;

   ddr3_resp_fifo #(.WIDTH(CMD_W), .DEPTH_BITS(CMD_FIFO_BITS)) u_cmd_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (i_app_en && o_app_rdy),
      .din       ({i_app_cmd, i_app_addr}),
      .pop_cnt   ({1'b0, cmd_pop}),
      .dout      (cmd_head),
      .dout_next (cmd_next),
      .full      (cmd_full),
      .empty     (cmd_empty),
      .count     (cmd_count)
   );

   ddr3_resp_fifo #(.WIDTH(36), .DEPTH_BITS(WDF_FIFO_BITS)) u_wdf_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (i_app_wdf_wren && o_app_wdf_rdy),
      .din       ({i_app_wdf_mask, i_app_wdf_data}),
      .pop_cnt   (wdf_pop_cnt),
      .dout      (wdf_head),
      .dout_next (wdf_next),
      .full      (wdf_full),
      .empty     (wdf_empty),
      .count     (wdf_count)
   );

   logic [2:0]                head_cmd;
   logic [MEM_ADDR_DEPTH-1:0] head_addr;
   logic [RAM_DEPTH_BITS-1:0] ram_idx;

   assign head_cmd  = cmd_head[CMD_W-1 -: 3];
   assign head_addr = cmd_head[MEM_ADDR_DEPTH-1:0];
   assign ram_idx   = head_addr[3 +: RAM_DEPTH_BITS];

   eng_state_e state, state_nx;
   logic       ram_we, rd_issue, illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      cmd_pop     = 1'b0;
      wdf_pop_cnt = 2'd0;
      ram_we      = 1'b0;
      rd_issue    = 1'b0;
      illegal     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!cmd_empty) begin
               if (head_cmd == CMD_WR) begin
                  if (wdf_count >= (WDF_FIFO_BITS + 1)'(2)) state_nx = ST_EXEC_WR;
               end else if (head_cmd == CMD_RD) begin
                  state_nx = ST_EXEC_RD;
               end else begin
                  cmd_pop = 1'b1;
                  illegal = 1'b1;
               end
            end
         end
         ST_EXEC_WR: begin
            cmd_pop     = 1'b1;
            wdf_pop_cnt = 2'd2;
            ram_we      = 1'b1;
            state_nx    = ST_IDLE;
         end
         ST_EXEC_RD: begin
            cmd_pop  = 1'b1;
            rd_issue = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   logic [63:0] mem [2 ** RAM_DEPTH_BITS];
   logic [63:0] wr_word;
   logic [7:0]  wr_be;
   logic [63:0] dpipe [RD_LATENCY];

   assign wr_word = {wdf_next[31:0], wdf_head[31:0]};
   assign wr_be   = ~{wdf_next[35:32], wdf_head[35:32]};

   // dpipe[0] doubles as the RAM read register; only the valid pipe needs reset
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int unsigned b = 0; b < 8; b++) begin
            if (wr_be[b]) mem[ram_idx][b*8 +: 8] <= wr_word[b*8 +: 8];
         end
      end
      dpipe[0] <= mem[ram_idx];
      for (int unsigned i = 1; i < RD_LATENCY; i++) dpipe[i] <= dpipe[i-1];
   end

   logic [RD_LATENCY-1:0] vld;
   logic                  hi_pending;
   logic [31:0]           hi_word;
   logic                  err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld        <= '0;
         hi_pending <= 1'b0;
         hi_word    <= '0;
         err_q      <= 1'b0;
      end else begin
         vld        <= RD_LATENCY'({vld, rd_issue});
         hi_pending <= vld[RD_LATENCY-1];
         hi_word    <= dpipe[RD_LATENCY-1][63:32];
         err_q      <= illegal;
      end
   end

   assign o_app_rd_data_valid = vld[RD_LATENCY-1] || hi_pending;
   assign o_app_rd_data_end   = hi_pending;
   assign o_app_rd_data       = vld[RD_LATENCY-1] ? dpipe[RD_LATENCY-1][31:0] :
                                hi_pending         ? hi_word : '0;
   assign o_err_stb           = err_q;

   logic sig_unused;
   assign sig_unused = ^{i_app_wdf_end, head_addr, cmd_next, cmd_count, wdf_empty};

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Self-checking bench for ddr3_app_responder: directed scenarios plus a randomized stall run
// checked against a byte-tracking memory model.
module tb_ddr3_app_responder;

   localparam int RD_LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        en = 1'b0;
   logic [2:0]  cmd = '0;
   logic [27:0] addr = '0;
   logic        wren = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  wmask = '0;
   logic        wend = 1'b0;

   logic        calib0, rdy0, wrdy0, rv0, rend0, err0;
   logic [31:0] rd0;
   logic        calib1, rdy1, wrdy1, rv1, rend1, err1;
   logic [31:0] rd1;
   logic        rdy, wrdy, rv, rend, err;
   logic [31:0] rdat;

   always #5 clk = ~clk;

   ddr3_app_responder #(.STALL_EN(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .o_init_calib_complete(calib0), .o_app_rdy(rdy0),
      .i_app_en(en && !sel), .i_app_cmd(cmd), .i_app_addr(addr), .o_app_wdf_rdy(wrdy0),
      .i_app_wdf_wren(wren && !sel), .i_app_wdf_data(wdata), .i_app_wdf_mask(wmask),
      .i_app_wdf_end(wend), .o_app_rd_data_valid(rv0), .o_app_rd_data_end(rend0),
      .o_app_rd_data(rd0), .o_err_stb(err0));

   ddr3_app_responder #(.STALL_EN(1)) u_dut_stall (
      .clk(clk), .rst_n(rst_n), .o_init_calib_complete(calib1), .o_app_rdy(rdy1),
      .i_app_en(en && sel), .i_app_cmd(cmd), .i_app_addr(addr), .o_app_wdf_rdy(wrdy1),
      .i_app_wdf_wren(wren && sel), .i_app_wdf_data(wdata), .i_app_wdf_mask(wmask),
      .i_app_wdf_end(wend), .o_app_rd_data_valid(rv1), .o_app_rd_data_end(rend1),
      .o_app_rd_data(rd1), .o_err_stb(err1));

   assign rdy  = sel ? rdy1  : rdy0;
   assign wrdy = sel ? wrdy1 : wrdy0;
   assign rv   = sel ? rv1   : rv0;
   assign rend = sel ? rend1 : rend0;
   assign rdat = sel ? rd1   : rd0;
   assign err  = sel ? err1  : err0;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int err_cnt = 0;
   int acc_cyc = 0;

   typedef struct { logic [31:0] d; logic e; int c; } beat_t;
   typedef struct { logic [31:0] d; logic e; logic [31:0] k; } exp_t;
   beat_t rx[$];
   exp_t  exq[$];

   bit [63:0] m_d [1024];
   bit [7:0]  m_k [1024];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rv) rx.push_back('{d: rdat, e: rend, c: cyc});
      if (err) err_cnt++;
   end

   // Reference memory: 64-bit words, byte address / 8, aliased modulo 1024 words
   function automatic int widx(input logic [27:0] a);
      return int'((a / 28'd8) % 28'd1024);
   endfunction

   function automatic void model_write(input logic [27:0] a, input logic [31:0] d0, input logic [3:0] m0,
                                       input logic [31:0] d1, input logic [3:0] m1);
      int i = widx(a);
      logic [63:0] w = {d1, d0};
      logic [7:0]  be = ~{m1, m0};
      for (int b = 0; b < 8; b++) begin
         if (be[b]) begin
            m_d[i][b*8 +: 8] = w[b*8 +: 8];
            m_k[i][b] = 1'b1;
         end
      end
   endfunction

   function automatic void model_read(input logic [27:0] a);
      int i = widx(a);
      logic [31:0] klo, khi;
      for (int b = 0; b < 4; b++) begin
         klo[b*8 +: 8] = {8{m_k[i][b]}};
         khi[b*8 +: 8] = {8{m_k[i][b+4]}};
      end
      exq.push_back('{d: m_d[i][31:0],  e: 1'b0, k: klo});
      exq.push_back('{d: m_d[i][63:32], e: 1'b1, k: khi});
   endfunction

   task automatic send_cmd(input logic [2:0] c, input logic [27:0] a);
      int n = 0;
      en = 1'b1; cmd = c; addr = a;
      while (!rdy && n < 2000) begin
         @(negedge clk); n++;
      end
      if (n >= 2000) begin
         checks++;
         $display("FAIL cmd_accept_timeout: rdy=%b required 1", rdy);
      end
      acc_cyc = cyc + 1;
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] m, input logic e);
      int n = 0;
      wren = 1'b1; wdata = d; wmask = m; wend = e;
      while (!wrdy && n < 2000) begin
         @(negedge clk); n++;
      end
      if (n >= 2000) begin
         checks++;
         $display("FAIL wdf_accept_timeout: wdf_rdy=%b required 1", wrdy);
      end
      @(negedge clk);
      wren = 1'b0; wend = 1'b0;
   endtask

   task automatic do_write(input logic [27:0] a, input logic [31:0] d0, input logic [3:0] m0,
                           input logic [31:0] d1, input logic [3:0] m1);
      send_beat(d0, m0, 1'b0);
      send_beat(d1, m1, 1'b1);
      send_cmd(3'b000, a);
      model_write(a, d0, m0, d1, m1);
   endtask

   task automatic do_read(input logic [27:0] a);
      send_cmd(3'b001, a);
      model_read(a);
   endtask

   task automatic wait_rx(input int n);
      int t = 0;
      while (rx.size() < n && t < 3000) begin
         @(negedge clk); t++;
      end
      if (rx.size() < n) begin
         checks++;
         $display("FAIL read_return_timeout: got %0d beats required %0d", rx.size(), n);
      end
   endtask

   task automatic test_reset();
      int rel;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({calib0, rdy0, wrdy0, rv0, rend0, err0, rd0} !== '0)
         $display("FAIL reset_outputs: got %h required 0", {calib0, rdy0, wrdy0, rv0, rend0, err0, rd0});
      else passed++;
      checks++;
      if ({calib1, rdy1, wrdy1, rv1, rend1, err1, rd1} !== '0)
         $display("FAIL reset_outputs_stall: got %h required 0", {calib1, rdy1, wrdy1, rv1, rend1, err1, rd1});
      else passed++;
      rst_n = 1'b1;
      rel = cyc;
      repeat (63) @(negedge clk);
      checks++;
      if ({calib0, rdy0, wrdy0} !== 3'b000)
         $display("FAIL calib_before_64: got %b required 000 at cycle %0d", {calib0, rdy0, wrdy0}, cyc - rel);
      else passed++;
      @(negedge clk);
      checks++;
      if ({calib0, rdy0, wrdy0} !== 3'b111)
         $display("FAIL calib_at_64: got %b required 111", {calib0, rdy0, wrdy0});
      else passed++;
      checks++;
      if (calib1 !== 1'b1) $display("FAIL calib_stall_inst: got %b required 1", calib1);
      else passed++;
   endtask

   task automatic test_write_read();
      exp_t e;
      sel = 1'b0;
      do_write(28'h40, 32'h11111111, 4'h0, 32'h22222222, 4'h0);
      repeat (8) @(negedge clk);
      rx.delete();
      do_read(28'h40);
      wait_rx(2);
      if (rx.size() >= 2) begin
         checks++;
         if (rx[0].d !== 32'h11111111 || rx[0].e !== 1'b0)
            $display("FAIL wr_rd_beat0: got %h/%b required 11111111/0", rx[0].d, rx[0].e);
         else passed++;
         checks++;
         if (rx[1].d !== 32'h22222222 || rx[1].e !== 1'b1)
            $display("FAIL wr_rd_beat1: got %h/%b required 22222222/1", rx[1].d, rx[1].e);
         else passed++;
         // accept edge, one idle-decision cycle, then RD_LATENCY from read issue
         checks++;
         if (rx[0].c != acc_cyc + 1 + RD_LAT || rx[1].c != acc_cyc + 2 + RD_LAT)
            $display("FAIL rd_latency: got %0d,%0d required %0d,%0d", rx[0].c - acc_cyc,
                     rx[1].c - acc_cyc, 1 + RD_LAT, 2 + RD_LAT);
         else passed++;
      end
      rx.delete();
      while (exq.size() > 0) e = exq.pop_front();
   endtask

   task automatic test_masked_write();
      exp_t e;
      do_write(28'h40, 32'hAAAAAAAA, 4'hF, 32'hBBBBBBBB, 4'h0);
      do_read(28'h40);
      wait_rx(2);
      if (rx.size() >= 2) begin
         checks++;
         if (rx[0].d !== 32'h11111111 || rx[1].d !== 32'hBBBBBBBB || rx[1].e !== 1'b1)
            $display("FAIL masked_write: got %h %h end %b required 11111111 bbbbbbbb end 1",
                     rx[0].d, rx[1].d, rx[1].e);
         else passed++;
      end
      rx.delete();
      while (exq.size() > 0) e = exq.pop_front();
   endtask

   task automatic test_data_first_illegal();
      int e0;
      exp_t e;
      beat_t r;
      send_beat(32'h33333333, 4'h0, 1'b0);
      send_beat(32'h44444444, 4'h0, 1'b1);
      repeat (10) @(negedge clk);
      send_cmd(3'b000, 28'h48);
      model_write(28'h48, 32'h33333333, 4'h0, 32'h44444444, 4'h0);
      do_read(28'h48);
      e0 = err_cnt;
      send_cmd(3'b010, 28'h40);
      repeat (6) @(negedge clk);
      checks++;
      if (err_cnt - e0 != 1) $display("FAIL illegal_err_stb: got %0d pulses required 1", err_cnt - e0);
      else passed++;
      do_read(28'h40);
      wait_rx(4);
      while (exq.size() > 0 && rx.size() > 0) begin
         e = exq.pop_front(); r = rx.pop_front();
         checks++;
         if ((((r.d ^ e.d) & e.k) !== '0) || r.e !== e.e)
            $display("FAIL data_first_read: got %h/%b required %h/%b", r.d, r.e, e.d, e.e);
         else passed++;
      end
      rx.delete(); exq.delete();
   endtask

   task automatic test_fifo_full();
      exp_t e;
      beat_t r;
      send_cmd(3'b000, 28'h80);
      model_write(28'h80, 32'h55555555, 4'h0, 32'h66666666, 4'h0);
      do_read(28'h80);
      do_read(28'h40);
      do_read(28'h48);
      en = 1'b1; cmd = 3'b001; addr = 28'h80;
      repeat (4) @(negedge clk);
      checks++;
      if (rdy0 !== 1'b0) $display("FAIL cmd_fifo_full_rdy: got %b required 0", rdy0);
      else passed++;
      fork
         send_cmd(3'b001, 28'h80);
         begin
            send_beat(32'h55555555, 4'h0, 1'b0);
            send_beat(32'h66666666, 4'h0, 1'b1);
         end
      join
      model_read(28'h80);
      wait_rx(8);
      while (exq.size() > 0 && rx.size() > 0) begin
         e = exq.pop_front(); r = rx.pop_front();
         checks++;
         if ((((r.d ^ e.d) & e.k) !== '0) || r.e !== e.e)
            $display("FAIL fifo_full_read_order: got %h/%b required %h/%b", r.d, r.e, e.d, e.e);
         else passed++;
      end
      rx.delete(); exq.delete();
   endtask

   task automatic test_stall_random();
      logic [27:0] wa [256];
      logic [3:0]  m0, m1;
      exp_t e;
      beat_t r;
      int t;
      sel = 1'b1;
      foreach (m_k[i]) m_k[i] = '0;
      repeat (2) @(negedge clk);
      rx.delete(); exq.delete();
      for (int i = 0; i < 256; i++) begin
         wa[i] = 28'(($urandom_range(0, 32767) << 13) | ($urandom_range(0, 63) << 3) | $urandom_range(0, 7));
         m0 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         m1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         do_write(wa[i], $urandom, m0, $urandom, m1);
      end
      for (int i = 0; i < 256; i++) do_read(wa[$urandom_range(0, 255)]);
      wait_rx(512);
      while (exq.size() > 0 && rx.size() > 0) begin
         e = exq.pop_front(); r = rx.pop_front();
         checks++;
         if ((((r.d ^ e.d) & e.k) !== '0) || r.e !== e.e)
            $display("FAIL stall_random_beat: got %h/%b required %h/%b mask %h", r.d, r.e, e.d, e.e, e.k);
         else passed++;
      end
      checks++;
      if (exq.size() != 0 || rx.size() != 0)
         $display("FAIL stall_random_count: leftover expected %0d observed %0d required 0/0", exq.size(), rx.size());
      else passed++;

      rx.delete(); exq.delete();
      for (int i = 0; i < 4; i++) do_read(wa[i]);
      t = 0;
      while (rx.size() == 0 && t < 500) begin
         @(negedge clk); t++;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({rdy1, wrdy1, rv1, rend1, err1, calib1, rd1} !== '0)
         $display("FAIL reset_mid_burst: got %h required 0", {rdy1, wrdy1, rv1, rend1, err1, calib1, rd1});
      else passed++;
      rx.delete(); exq.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (rx.size() != 0) $display("FAIL valid_after_reset: got %0d beats required 0", rx.size());
      else passed++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_masked_write();
      test_data_first_illegal();
      test_fifo_full();
      test_stall_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
